rename_regfile: RTL and testbench
=================================

Name: rename_regfile

Overview:
- Architectural register file with per-register ROB rename tags.
- Sits downstream of the ROB commit port and alongside issue.
- Issue reads source operands as either a ready value or a pending ROB tag, and records the new destination tag. On commit, ROB results are written back and the tag is cleared.
- Rollback flushes all pending tags.

Parameters:
- TAG_W, 6, width of a ROB entry tag.
- NULL_TAG, 6'd32, tag value meaning "no producer / value ready".
- NREG, 32, number of architectural registers (x0..x31).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low; sampled on posedge clk only.
- rdy  in  1  global enable; when low, all state holds.
- rollback  in  1  flush all rename tags.
- issue_sgn  in  1  an instruction is issued this cycle.
- issue_rd  in  6  destination register; values >=32 mean no destination.
- issue_tag  in  TAG_W  ROB entry allocated to the issued instruction.
- rs1_addr  in  6  source 1 register index.
- rs2_addr  in  6  source 2 register index.
- rs1_val  out  32  source 1 value (valid when rs1_tag==NULL_TAG).
- rs1_tag  out  TAG_W  source 1 pending producer, or NULL_TAG.
- rs2_val  out  32  source 2 value.
- rs2_tag  out  TAG_W  source 2 pending producer, or NULL_TAG.
- commit_sgn  in  1  ROB commit strobe.
- commit_entry  in  TAG_W  committing ROB entry.
- commit_des  in  6  committing destination register.
- commit_result  in  32  committed value.

Behaviour:
- Storage: val[0..31] (32 bits each) and tag[0..31] (TAG_W each).
- Reset (rst==0 at posedge): all val=0, all tag=NULL_TAG. Reset has priority over rdy, rollback, issue and commit, including mid-operation.
- rdy==0: no state change. Read outputs still track the current storage.
- Reads are combinational, zero latency:
  - addr==0 or addr>=32 -> val=0, tag=NULL_TAG.
  - Otherwise -> val[addr], tag[addr], subject to commit bypass (see Optional Feature).
- Commit (commit_sgn, rdy, rst high), registered at the next posedge:
  - If 1<=commit_des<=31: val[commit_des] <= commit_result.
  - If tag[commit_des]==commit_entry, it is cleared to NULL_TAG. Otherwise the tag is kept, because a younger producer exists.
  - commit_des==0 or >=32: no write.
- Issue (issue_sgn, rdy): if 1<=issue_rd<=31, tag[issue_rd] <= issue_tag. x0 is never tagged.
- Same cycle, commit and issue to the same register: the value is written and the tag becomes issue_tag (issue wins the tag).
- Same cycle, source read and issue to the same register: the read returns the pre-issue tag/value. The caller handles the rd==rs case by issuing after reading.
- Rollback (rdy high): all tags <= NULL_TAG; values are kept.
  - A commit in the same cycle as rollback still writes its value.
  - An issue in the same cycle as rollback is discarded; rollback wins.
- Wrap-around: tags are opaque equality compares, with no ordering arithmetic. ROB entry reuse is safe because a stale tag is always overwritten by issue before reuse.

Optional Feature:
- Macro: COMMIT_BYPASS_EN.
- Defined: a read whose register matches a same-cycle commit_des, where tag[addr]==commit_entry and commit_sgn is high, returns val=commit_result and tag=NULL_TAG combinationally. This saves one cycle of RS wakeup.
- Undefined: reads return pure storage contents, and the committed value becomes visible on the cycle after commit.

Test Plan:
- Hold rst=0 for 2 cycles, then read x5 -> val=0, tag=NULL_TAG (32). Read x0 -> val=0, tag=32.
- Issue rd=5, tag=3; next cycle read x5 -> tag=3. Commit entry=3, des=5, result=0xDEADBEEF; next cycle read x5 -> val=0xDEADBEEF, tag=32.
- Issue rd=7 tag=1, then issue rd=7 tag=9. Commit entry=1 des=7 result=0x11 -> val[7]=0x11, tag stays 9.
- Same cycle: commit entry=4 des=8 result=0x22 and issue rd=8 tag=12 -> next cycle val=0x22, tag=12.
- Tag x2=6 and x3=7, then assert rollback with commit des=2 entry=6 result=0x55 and issue rd=3 tag=10 -> x2: val=0x55, tag=32; x3: tag=32.
- With COMMIT_BYPASS_EN: x9 tagged 2, commit entry=2 des=9 result=0x77 while reading rs1=9 -> same-cycle rs1_val=0x77, rs1_tag=32. Without the macro -> rs1_tag=2 that cycle, and val=0x77, tag=32 the next cycle.
- Issue or commit to x0 with value 0xFFFF -> x0 still reads val=0, tag=32.

Source files
------------

// File: rtl/rename_regfile.sv
// rename_regfile: architectural register file with per-register ROB rename tags.
//
// Each architectural register holds a committed value and the tag of its
// youngest in-flight producer (NULL_TAG when the value is ready). Issue reads
// two sources combinationally and tags the destination. Commit writes back a
// ROB result and clears the tag only if it still names the committing entry.
// Rollback clears every tag and keeps the values.
//
// Ports:
//   clk, rst (sync, active-low) : clock / reset
//   rdy                         : global enable; state holds while low
//   rollback                    : flush all rename tags
//   issue_sgn/issue_rd/issue_tag: destination rename at issue
//   rs1_addr/rs2_addr           : source register indices
//   rs1_val/rs1_tag, rs2_val/rs2_tag : source value or pending producer tag
//   commit_sgn/commit_entry/commit_des/commit_result : ROB commit port
//
// Optional build macro: COMMIT_BYPASS_EN
//   Defined  : a source read that matches a same-cycle commit whose entry is
//              the register's current producer returns commit_result with
//              NULL_TAG combinationally.
//   Undefined: reads return storage only; commits show up a cycle later.
module rename_regfile #(
  parameter int unsigned       TAG_W    = 6,
  parameter logic [TAG_W-1:0]  NULL_TAG = TAG_W'(32),
  parameter int unsigned       NREG     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rollback,
  input  logic             issue_sgn,
  input  logic [5:0]       issue_rd,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [5:0]       rs1_addr,
  input  logic [5:0]       rs2_addr,
  output logic [31:0]      rs1_val,
  output logic [TAG_W-1:0] rs1_tag,
  output logic [31:0]      rs2_val,
  output logic [TAG_W-1:0] rs2_tag,
  input  logic             commit_sgn,
  input  logic [TAG_W-1:0] commit_entry,
  input  logic [5:0]       commit_des,
  input  logic [31:0]      commit_result
);

  localparam int unsigned AW = $clog2(NREG);

  logic [31:0]      val_q [NREG];
  logic [TAG_W-1:0] tag_q [NREG];

  // x0 and indices beyond the file are never written and always read as ready 0.
  function automatic logic reg_ok(input logic [5:0] a);
    return (a != '0) && (32'(a) < NREG);
  endfunction

  function automatic logic [AW-1:0] idx(input logic [5:0] a);
    return a[AW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        val_q[AW'(i)] <= '0;
        tag_q[AW'(i)] <= NULL_TAG;
      end
    end else if (rdy) begin
      if (commit_sgn && reg_ok(commit_des)) begin
        val_q[idx(commit_des)] <= commit_result;
        // A mismatching tag means a younger producer was issued; keep waiting on it.
        if (tag_q[idx(commit_des)] == commit_entry)
          tag_q[idx(commit_des)] <= NULL_TAG;
      end
      // Later nonblocking writes win: rollback overrides everything, and an
      // issue overrides a same-register commit tag clear.
      if (rollback) begin
        for (int unsigned i = 0; i < NREG; i++)
          tag_q[AW'(i)] <= NULL_TAG;
      end else if (issue_sgn && reg_ok(issue_rd)) begin
        tag_q[idx(issue_rd)] <= issue_tag;
      end
    end
  end

  always_comb begin
    rs1_val = '0;
    rs1_tag = NULL_TAG;
    if (reg_ok(rs1_addr)) begin
      rs1_val = val_q[idx(rs1_addr)];
      rs1_tag = tag_q[idx(rs1_addr)];
`ifdef COMMIT_BYPASS_EN
      if (commit_sgn && commit_des == rs1_addr && tag_q[idx(rs1_addr)] == commit_entry) begin
        rs1_val = commit_result;
        rs1_tag = NULL_TAG;
      end
`endif
    end
  end

  always_comb begin
    rs2_val = '0;
    rs2_tag = NULL_TAG;
    if (reg_ok(rs2_addr)) begin
      rs2_val = val_q[idx(rs2_addr)];
      rs2_tag = tag_q[idx(rs2_addr)];
`ifdef COMMIT_BYPASS_EN
      if (commit_sgn && commit_des == rs2_addr && tag_q[idx(rs2_addr)] == commit_entry) begin
        rs2_val = commit_result;
        rs2_tag = NULL_TAG;
      end
`endif
    end
  end

endmodule

// File: tb/tb_rename_regfile.sv
// tb_rename_regfile: directed scenarios plus randomized traffic, checked
// against a behavioural model of the register file held in plain arrays.
module tb_rename_regfile;

  localparam int TAG_W = 6;
  localparam logic [TAG_W-1:0] NULL_TAG = 6'd32;

  logic             clk;
  logic             rst;
  logic             rdy;
  logic             rollback;
  logic             issue_sgn;
  logic [5:0]       issue_rd;
  logic [TAG_W-1:0] issue_tag;
  logic [5:0]       rs1_addr;
  logic [5:0]       rs2_addr;
  logic [31:0]      rs1_val;
  logic [TAG_W-1:0] rs1_tag;
  logic [31:0]      rs2_val;
  logic [TAG_W-1:0] rs2_tag;
  logic             commit_sgn;
  logic [TAG_W-1:0] commit_entry;
  logic [5:0]       commit_des;
  logic [31:0]      commit_result;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0]      m_val [32];
  logic [TAG_W-1:0] m_tag [32];

  rename_regfile #(.TAG_W(TAG_W), .NULL_TAG(NULL_TAG), .NREG(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .issue_sgn(issue_sgn), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_val(rs1_val), .rs1_tag(rs1_tag), .rs2_val(rs2_val), .rs2_tag(rs2_tag),
    .commit_sgn(commit_sgn), .commit_entry(commit_entry),
    .commit_des(commit_des), .commit_result(commit_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected read for one source port, from the model's current contents.
  task automatic model_read(input logic [5:0] a, output logic [31:0] v, output logic [TAG_W-1:0] t);
    v = '0;
    t = NULL_TAG;
    if (a >= 6'd1 && a <= 6'd31) begin
      v = m_val[a[4:0]];
      t = m_tag[a[4:0]];
`ifdef COMMIT_BYPASS_EN
      if (commit_sgn && commit_des == a && m_tag[a[4:0]] == commit_entry) begin
        v = commit_result;
        t = NULL_TAG;
      end
`endif
    end
  endtask

  // Applies one clock edge's worth of the register-file rules to the model.
  task automatic model_step();
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = '0;
        m_tag[i] = NULL_TAG;
      end
    end else if (rdy) begin
      if (commit_sgn && commit_des >= 6'd1 && commit_des <= 6'd31) begin
        m_val[commit_des[4:0]] = commit_result;
        if (m_tag[commit_des[4:0]] == commit_entry) m_tag[commit_des[4:0]] = NULL_TAG;
      end
      if (rollback) begin
        for (int i = 0; i < 32; i++) m_tag[i] = NULL_TAG;
      end else if (issue_sgn && issue_rd >= 6'd1 && issue_rd <= 6'd31) begin
        m_tag[issue_rd[4:0]] = issue_tag;
      end
    end
  endtask

  // Checks both read ports against the model mid-cycle, then clocks once.
  task automatic cycle();
    logic [31:0]      ev;
    logic [TAG_W-1:0] et;
    @(negedge clk);
    model_read(rs1_addr, ev, et);
    check("rs1_val", rs1_val, ev);
    check("rs1_tag", 32'(rs1_tag), 32'(et));
    model_read(rs2_addr, ev, et);
    check("rs2_val", rs2_val, ev);
    check("rs2_tag", 32'(rs2_tag), 32'(et));
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    rollback   = 1'b0;
    issue_sgn  = 1'b0;
    commit_sgn = 1'b0;
  endtask

  task automatic do_issue(input logic [5:0] rd, input logic [TAG_W-1:0] t);
    issue_sgn = 1'b1;
    issue_rd  = rd;
    issue_tag = t;
  endtask

  task automatic do_commit(input logic [TAG_W-1:0] e, input logic [5:0] d, input logic [31:0] r);
    commit_sgn    = 1'b1;
    commit_entry  = e;
    commit_des    = d;
    commit_result = r;
  endtask

  task automatic peek(input string name, input logic [5:0] a, input logic [31:0] ev, input logic [TAG_W-1:0] et);
    rs1_addr = a;
    #1;
    check({name, "_val"}, rs1_val, ev);
    check({name, "_tag"}, 32'(rs1_tag), 32'(et));
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; idle();
    issue_rd = '0; issue_tag = '0; commit_entry = '0; commit_des = '0; commit_result = '0;
    rs1_addr = 6'd5; rs2_addr = 6'd0;
    for (int i = 0; i < 32; i++) begin
      m_val[i] = 32'hx;
      m_tag[i] = 6'hx;
    end
    @(posedge clk); model_step(); #1;
    cycle();
    rst = 1'b1;
    peek("reset_x5", 6'd5, 32'h0, NULL_TAG);
    peek("reset_x0", 6'd0, 32'h0, NULL_TAG);

    do_issue(6'd5, 6'd3); cycle(); idle();
    peek("issue_x5", 6'd5, 32'h0, 6'd3);
    do_commit(6'd3, 6'd5, 32'hDEADBEEF); cycle(); idle();
    peek("commit_x5", 6'd5, 32'hDEADBEEF, NULL_TAG);

    do_issue(6'd7, 6'd1); cycle();
    do_issue(6'd7, 6'd9); cycle(); idle();
    do_commit(6'd1, 6'd7, 32'h11); cycle(); idle();
    peek("younger_x7", 6'd7, 32'h11, 6'd9);

    do_commit(6'd4, 6'd8, 32'h22); do_issue(6'd8, 6'd12); cycle(); idle();
    peek("same_cyc_x8", 6'd8, 32'h22, 6'd12);

    do_issue(6'd2, 6'd6); cycle();
    do_issue(6'd3, 6'd7); cycle(); idle();
    rollback = 1'b1; do_commit(6'd6, 6'd2, 32'h55); do_issue(6'd3, 6'd10); cycle(); idle();
    peek("rollback_x2", 6'd2, 32'h55, NULL_TAG);
    peek("rollback_x3", 6'd3, 32'h0, NULL_TAG);
    peek("rollback_x8", 6'd8, 32'h22, NULL_TAG);

    do_issue(6'd9, 6'd2); cycle(); idle();
    do_commit(6'd2, 6'd9, 32'h77);
`ifdef COMMIT_BYPASS_EN
    peek("bypass_x9", 6'd9, 32'h77, NULL_TAG);
`else
    peek("nobypass_x9", 6'd9, 32'h0, 6'd2);
`endif
    cycle(); idle();
    peek("after_x9", 6'd9, 32'h77, NULL_TAG);

    do_issue(6'd0, 6'd5); do_commit(6'd5, 6'd0, 32'hFFFF); cycle(); idle();
    peek("x0_const", 6'd0, 32'h0, NULL_TAG);
    do_issue(6'd8, 6'd14); cycle(); idle();
    do_commit(6'd14, 6'd40, 32'hBAD); do_issue(6'd41, 6'd3); cycle(); idle();
    peek("oor_x8", 6'd8, 32'h22, 6'd14);
    peek("oor_read", 6'd40, 32'h0, NULL_TAG);

    rdy = 1'b0; do_issue(6'd10, 6'd5); do_commit(6'd14, 6'd8, 32'h99); cycle(); idle(); rdy = 1'b1;
    peek("hold_x10", 6'd10, 32'h0, NULL_TAG);
    peek("hold_x8", 6'd8, 32'h22, 6'd14);

    // Reset mid-operation beats a concurrent issue and commit.
    rst = 1'b0; do_issue(6'd4, 6'd1); do_commit(6'd14, 6'd8, 32'h5); cycle(); idle(); rst = 1'b1;
    peek("midrst_x8", 6'd8, 32'h0, NULL_TAG);

    for (int n = 0; n < 3000; n++) begin
      logic [5:0] pick;
      rst      = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      rdy      = ($urandom_range(0, 9) != 0);
      rollback = ($urandom_range(0, 29) == 0);
      issue_sgn = $urandom_range(0, 1) == 1;
      issue_rd  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 31));
      issue_tag = 6'($urandom_range(0, 31));
      commit_sgn = $urandom_range(0, 1) == 1;
      commit_des = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 31));
      commit_entry = ($urandom_range(0, 2) != 0 && commit_des < 6'd32) ? m_tag[commit_des[4:0]]
                                                                     : 6'($urandom_range(0, 31));
      commit_result = $urandom;
      pick = ($urandom_range(0, 2) == 0) ? commit_des : 6'($urandom_range(0, 63));
      rs1_addr = pick;
      rs2_addr = 6'($urandom_range(0, 63));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
